// File: rtl/ccff_bitstream_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader_if
//
// Configuration-word stream between a bitstream source and the loader.
//   cfg_data  : configuration word, bit 0 (leftmost) is shifted first
//   cfg_valid : source has a word on cfg_data
//   cfg_ready : loader takes cfg_data in this cycle
// A word moves on a prog_clk edge where cfg_valid and cfg_ready are both high.
//
// Modports:
//   master : bitstream source
//   slave  : ccff_bitstream_loader
// ---------------------------------------------------------------------------
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);

  logic [0:WORD_W-1] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface : ccff_bitstream_loader_if

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Serialises configuration words onto the head of a fabric configuration
// chain (ccff_head) and drives the shift enable used by an external
// clock-gating cell to gate prog_clk into the chain. Loaded bits are counted
// against the fixed chain length; a partial final word is truncated.
//
// Optional feature, macro CCFF_READBACK_EN:
//   After the last bit the chain is circulated once (ccff_tail -> ccff_head)
//   and a CRC-16-CCITT of the tail stream is compared with the CRC of the
//   loaded stream. A mismatch raises the sticky 'error' output. Without the
//   macro there is no CRC logic and 'error' is tied low.
//
// Parameters:
//   WORD_W    : configuration word width
//   CHAIN_LEN : number of flops in the chain (>= 1)
//   CNT_W     : bit-counter width (2**CNT_W > CHAIN_LEN)
//
// Ports:
//   prog_clk       : programming clock, the only clock
//   prog_reset     : synchronous, active-high reset
//   start          : one-cycle load request, honoured only when idle
//   cfg            : word stream (slave side of ccff_bitstream_loader_if)
//   ccff_head      : serial bit into the chain head (0 while not shifting)
//   ccff_tail      : serial bit from the chain tail
//   chain_shift_en : chain shifts at the end of every cycle this is high
//   bit_count      : bits shifted so far in the current load (saturating)
//   busy           : a load is in progress
//   done           : one-cycle pulse when a load completes
//   error          : readback mismatch, sticky until the next accepted start
//
// All outputs are decoded from registered state and change only on prog_clk
// rising edges, except ccff_head during readback, which follows ccff_tail
// combinationally so the chain recirculates without an extra flop.
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    prog_clk,
  input  logic                    prog_reset,
  input  logic                    start,
  ccff_bitstream_loader_if.slave  cfg,
  output logic                    ccff_head,
  input  logic                    ccff_tail,
  output logic                    chain_shift_en,
  output logic [0:CNT_W-1]        bit_count,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
`ifdef CCFF_READBACK_EN
    VERIFY = 3'd4,
`endif
    DONE   = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [0:WORD_W-1] shreg_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              ready_c;
  logic              last_bit_c;

  assign cfg.cfg_ready = ready_c;
  assign bit_count     = bit_cnt_q;

  // -------------------------------------------------------------------------
  // Readback CRC (optional)
  // -------------------------------------------------------------------------
`ifdef CCFF_READBACK_EN
  // CRC-16-CCITT, one bit per cycle, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc,
                                           input logic        din);
    logic fb;
    fb = crc[15] ^ din;
    return (crc << 1) ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0]      crc_load_q;
  logic [15:0]      crc_ver_q;
  logic [15:0]      crc_ver_d;
  logic [CNT_W-1:0] ver_cnt_q;
  logic             err_q;

  assign crc_ver_d = crc_step(crc_ver_q, ccff_tail);
  assign error     = err_q;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_load_q <= 16'hFFFF;
      crc_ver_q  <= 16'hFFFF;
      ver_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          crc_load_q <= 16'hFFFF;
          crc_ver_q  <= 16'hFFFF;
          ver_cnt_q  <= '0;
          if (start) err_q <= 1'b0;
        end
        SHIFT: crc_load_q <= crc_step(crc_load_q, shreg_q[idx_q]);
        VERIFY: begin
          ver_cnt_q <= ver_cnt_q + 1'b1;
          crc_ver_q <= crc_ver_d;
          // Compare against the CRC including this cycle's tail bit.
          if (ver_cnt_q == CNT_LAST) err_q <= (crc_load_q != crc_ver_d);
        end
        default: ;
      endcase
    end
  end
`else
  assign error = 1'b0;

  // The tail is only observed during readback.
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block order.
    if (prog_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d        = state_q;
    ready_c        = 1'b0;
    chain_shift_en = 1'b0;
    ccff_head      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    last_bit_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end

      LOAD: begin
        busy    = 1'b1;
        ready_c = 1'b1;
        if (cfg.cfg_valid) state_d = SHIFT;
      end

      SHIFT: begin
        busy           = 1'b1;
        chain_shift_en = 1'b1;
        ccff_head      = shreg_q[idx_q];
        last_bit_c     = (bit_cnt_q == CNT_LAST);
        if (last_bit_c) begin
`ifdef CCFF_READBACK_EN
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end else if (idx_q == IDX_LAST) begin
          // Word exhausted with chain bits still to go: fetch the next one.
          state_d = LOAD;
        end
      end

`ifdef CCFF_READBACK_EN
      VERIFY: begin
        busy           = 1'b1;
        chain_shift_en = 1'b1;
        ccff_head      = ccff_tail;
        if (ver_cnt_q == CNT_LAST) state_d = DONE;
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Word shift register
  // -------------------------------------------------------------------------
  // NOTE: the shift register carries data only and is always written by a
  // handshake before it is read, so it has no reset.
  always_ff @(posedge prog_clk) begin
    if (state_q == LOAD && cfg.cfg_valid) shreg_q <= cfg.cfg_data;
  end

  // -------------------------------------------------------------------------
  // Word-bit index and chain bit counter
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      idx_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: bit_cnt_q <= '0;
        LOAD: if (cfg.cfg_valid) idx_q <= '0;
        SHIFT: begin
          idx_q <= idx_q + 1'b1;
          if (bit_cnt_q != CNT_FULL) bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : ccff_bitstream_loader
